// File: rtl/cdb_broadcaster.sv
// cdb_broadcaster: buffers ALU and LSB results in per-source FIFOs and broadcasts
// up to two of them per cycle on a registered two-lane common data bus.
module cdb_broadcaster #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        flush,
  input  logic        alu_ready,
  input  logic [3:0]  alu_tag,
  input  logic [31:0] alu_result,
  input  logic        lsb_ready,
  input  logic [3:0]  lsb_tag,
  input  logic [31:0] lsb_result,
  output logic [73:0] cdb,
  output logic        alu_almost_full,
  output logic        lsb_almost_full,
  output logic        overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  localparam logic [PW:0] AF = (PW+1)'(DEPTH - 1);
  localparam logic [PW:0] TWO = (PW+1)'(2);
  logic [35:0] mem_q [2][DEPTH];
  logic [PW-1:0] rp_q [2];
  logic [PW-1:0] wp_q [2];
  logic [PW:0] cnt_q [2];
  logic [PW:0] cnt_d [2];
  logic [PW:0] cp [2];
  logic [1:0] pop [2];
  logic [35:0] in_e [2];
  logic [35:0] head [2];
  logic [35:0] nxt [2];
  logic [1:0] in_v, ok, ne, two, af_q, af_d;
  logic [36:0] lane0, lane1;
  logic [73:0] cdb_q, cdb_d;
  logic ovf_q, ovf_d;
  // Pops are chosen from pre-edge contents; pushes land after the pops free space.
  always_comb begin
    in_v = {lsb_ready, alu_ready};
    in_e[0] = {alu_tag, alu_result};
    in_e[1] = {lsb_tag, lsb_result};
    for (int s = 0; s < 2; s++) begin
      ne[s] = cnt_q[s] != '0;
      two[s] = cnt_q[s] >= TWO;
      head[s] = mem_q[s][rp_q[s]];
      nxt[s] = mem_q[s][rp_q[s] + PW'(1)];
    end
    pop[0] = !ne[0] ? 2'd0 : (ne[1] || !two[0]) ? 2'd1 : 2'd2;
    pop[1] = !ne[1] ? 2'd0 : (ne[0] || !two[1]) ? 2'd1 : 2'd2;
    lane0 = ne[0] ? {1'b1, head[0]} : ne[1] ? {1'b1, head[1]} : '0;
    lane1 = &ne ? {1'b1, head[1]} : (ne[0] && two[0]) ? {1'b1, nxt[0]} :
            (ne[1] && two[1]) ? {1'b1, nxt[1]} : '0;
    cdb_d = flush ? '0 : {lane1, lane0};
    for (int s = 0; s < 2; s++) begin
      cp[s] = cnt_q[s] - (PW+1)'(pop[s]);
      ok[s] = in_v[s] && (cp[s] < FULL) && !flush;
      cnt_d[s] = flush ? '0 : cp[s] + (PW+1)'(ok[s]);
      af_d[s] = cnt_d[s] >= AF;
    end
    ovf_d = ovf_q | (!flush && |(in_v & ~ok));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < 2; s++) begin
        rp_q[s] <= '0;
        wp_q[s] <= '0;
        cnt_q[s] <= '0;
      end
      cdb_q <= '0;
      af_q <= '0;
      ovf_q <= 1'b0;
    end else if (rdy) begin
      for (int s = 0; s < 2; s++) begin
        rp_q[s] <= flush ? '0 : rp_q[s] + PW'(pop[s]);
        wp_q[s] <= flush ? '0 : wp_q[s] + PW'(ok[s]);
        cnt_q[s] <= cnt_d[s];
      end
      cdb_q <= cdb_d;
      af_q <= af_d;
      ovf_q <= ovf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (rdy)
      for (int s = 0; s < 2; s++)
        if (ok[s]) mem_q[s][wp_q[s]] <= in_e[s];
  end
  assign cdb = cdb_q;
  assign alu_almost_full = af_q[0];
  assign lsb_almost_full = af_q[1];
  assign overflow = ovf_q;
endmodule
